// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall bus width, stall vector encodings,
// FSM state encodings and the stall-priority helper.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // EX holds everything up to and including EX; it outranks an ID hold.
    function automatic stall_bus_t stall_select(input logic req_id, input logic req_ex);
        stall_bus_t vec;
        if (req_ex) begin
            vec = STALL_EX;
        end else if (req_id) begin
            vec = STALL_ID;
        end else begin
            vec = STALL_NONE;
        end
        return vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles and a sticky
// timeout flag raised when the count reaches WDOG_LIMIT.
module stall_wdog #(
    parameter logic [7:0] WDOG_LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic timeout_o
);

    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       timeout_r;

    // Next consecutive-stall count: saturate at 8'hFF, clear on any unstalled cycle.
    always_comb begin
        cnt_nxt_s = 8'h00;
        if (stall_active) begin
            if (cnt_r == 8'hFF) begin
                cnt_nxt_s = cnt_r;
            end else begin
                cnt_nxt_s = cnt_r + 8'd1;
            end
        end else begin
            cnt_nxt_s = 8'h00;
        end
    end

    // Consecutive-stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'h00;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if (stall_active && (cnt_nxt_s == WDOG_LIMIT)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout_o = timeout_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector generation, one-cycle flush/redirect FSM,
// stall statistics and the stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [7:0] WDOG_LIMIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        flushreq,
    input  logic [31:0] flush_pc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cycles_o
);

    logic [0:0]  state_r;
    logic [0:0]  state_nxt_s;
    logic [31:0] new_pc_r;
    logic [31:0] stall_cycles_r;
    stall_bus_t  stall_s;
    logic        stall_active_s;

    // Stall vector: silent during reset and FLUSH; a flush request outranks any hold.
    always_comb begin
        stall_s = STALL_NONE;
        if (rst) begin
            stall_s = STALL_NONE;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (flushreq) begin
                        stall_s = STALL_NONE;
                    end else begin
                        stall_s = stall_select(stallreq_id, stallreq_ex);
                    end
                end
                ST_FLUSH: stall_s = STALL_NONE;
                default:  stall_s = STALL_NONE;
            endcase
        end
    end

    // Next state: a flush request from either state (re)enters FLUSH for one cycle.
    always_comb begin
        state_nxt_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (flushreq) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flushreq) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Redirect address captured with each accepted flush request, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_pc_r <= ZERO_WORD;
        end else if (flushreq) begin
            new_pc_r <= flush_pc_i;
        end else begin
            new_pc_r <= new_pc_r;
        end
    end

    assign stall_active_s = (stall_s != STALL_NONE);

    // Total stalled-cycle count; wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if (stall_active_s) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    stall_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall_active_s),
        .timeout_o    (stall_timeout_o)
    );

    assign stall_o        = stall_s;
    assign flush_o        = (state_r == ST_FLUSH);
    assign new_pc_o       = new_pc_r;
    assign stall_cycles_o = stall_cycles_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle-level behavioural model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        flushreq = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_timeout_o;
    logic [31:0] stall_cycles_o;

    int tests = 0;
    int fails = 0;

    // Model state: "a flush cycle is in progress", redirect target, run length,
    // sticky timeout, total stalled cycles (plus an offset used for the wrap test).
    logic        m_flush;
    logic [31:0] m_pc;
    int          m_run;
    logic        m_to;
    logic [31:0] m_cnt;
    logic [31:0] m_bias = 32'h0;

    pipe_ctrl #(.WDOG_LIMIT(8'd255)) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_id     (stallreq_id),
        .stallreq_ex     (stallreq_ex),
        .flushreq        (flushreq),
        .flush_pc_i      (flush_pc_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o),
        .stall_timeout_o (stall_timeout_o),
        .stall_cycles_o  (stall_cycles_o)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_stall();
        if (rst || m_flush || flushreq) return 6'b000000;
        if (stallreq_ex) return 6'b001111;
        if (stallreq_id) return 6'b000111;
        return 6'b000000;
    endfunction

    // Behavioural model advanced once per clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_flush <= 1'b0;
            m_pc    <= 32'h0;
            m_run   <= 0;
            m_to    <= 1'b0;
            m_cnt   <= 32'h0;
        end else begin
            if (exp_stall() != 6'b000000) begin
                m_run <= (m_run < 255) ? m_run + 1 : 255;
                if (m_run + 1 >= 255) m_to <= 1'b1;
                m_cnt <= m_cnt + 32'd1;
            end else begin
                m_run <= 0;
            end
            if (flushreq) m_pc <= flush_pc_i;
            m_flush <= flushreq;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_stall",   {26'h0, stall_o},         {26'h0, exp_stall()});
        chk("model_flush",   {31'h0, flush_o},         {31'h0, m_flush});
        chk("model_new_pc",  new_pc_o,                 m_pc);
        chk("model_timeout", {31'h0, stall_timeout_o}, {31'h0, m_to});
        chk("model_cycles",  stall_cycles_o,           m_cnt + m_bias);
    endtask

    task automatic step(input logic id, input logic ex, input logic fr, input logic [31:0] pc);
        @(posedge clk);
        #1;
        stallreq_id = id;
        stallreq_ex = ex;
        flushreq    = fr;
        flush_pc_i  = pc;
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_stall",   {26'h0, stall_o}, 32'h0);
        chk("rst_flush",   {31'h0, flush_o}, 32'h0);
        chk("rst_pc",      new_pc_o, 32'h0);
        chk("rst_timeout", {31'h0, stall_timeout_o}, 32'h0);
        chk("rst_cycles",  stall_cycles_o, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Accumulate five stalled cycles, then reset mid-cycle
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_cycles", stall_cycles_o, 32'd5);
        #2 stallreq_id = 1'b1;
        rst = 1'b1;
        m_bias = 32'h0;
        #1;
        chk("async_rst_stall",  {26'h0, stall_o}, 32'h0);
        chk("async_rst_cycles", stall_cycles_o, 32'h0);
        chk("async_rst_flush",  {31'h0, flush_o}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("run_after_rst", {26'h0, stall_o}, 32'h07);

        // Stall priority
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("prio_both", {26'h0, stall_o}, 32'h0F);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("prio_id", {26'h0, stall_o}, 32'h07);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("prio_none", {26'h0, stall_o}, 32'h00);

        // Single flush overriding an EX stall
        step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        chk("flush_req_stall", {26'h0, stall_o}, 32'h0);
        chk("flush_req_flush", {31'h0, flush_o}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("flush_pulse", {31'h0, flush_o}, 32'h1);
        chk("flush_pc",    new_pc_o, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("flush_end", {31'h0, flush_o}, 32'h0);

        // Back-to-back flush
        step(1'b0, 1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h300);
        chk("b2b_flush1", {31'h0, flush_o}, 32'h1);
        chk("b2b_pc1",    new_pc_o, 32'h200);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("b2b_flush2", {31'h0, flush_o}, 32'h1);
        chk("b2b_pc2",    new_pc_o, 32'h300);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("b2b_end", {31'h0, flush_o}, 32'h0);

        // Stall-cycle counter wrap
        @(posedge clk);
        #1;
        force dut.stall_cycles_r = 32'hFFFF_FFFF;
        m_bias = 32'hFFFF_FFFF - m_cnt;
        #1;
        release dut.stall_cycles_r;
        stallreq_id = 1'b1;
        @(negedge clk);
        compare_model();
        chk("wrap_pre", stall_cycles_o, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_post", stall_cycles_o, 32'h0);

        // Watchdog: 255 consecutive stalled cycles
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 255; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wdog_254", {31'h0, stall_timeout_o}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wdog_255", {31'h0, stall_timeout_o}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wdog_sticky", {31'h0, stall_timeout_o}, 32'h1);
        chk("wdog_cnt_clear", {24'h0, dut.u_wdog.cnt_r}, 32'h0);

        // Reset during FLUSH aborts the flush
        step(1'b0, 1'b0, 1'b1, 32'h400);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("abort_pre", {31'h0, flush_o}, 32'h1);
        #2 rst = 1'b1;
        m_bias = 32'h0;
        #1;
        chk("abort_flush",   {31'h0, flush_o}, 32'h0);
        chk("abort_timeout", {31'h0, stall_timeout_o}, 32'h0);
        chk("abort_pc",      new_pc_o, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("abort_post1", {31'h0, flush_o}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("abort_post2", {31'h0, flush_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
